// File: rtl/btn_event.sv
// Debounces strobed button samples and classifies each press as press/short/long/reset-hold.
// Emits registered 1-cycle event pulses, sticky status bits and a reset request on release.
module btn_event #(
   parameter int DEB_N      = 4,
   parameter int CNT_W      = 16,
   parameter int LONG_TICKS = 1000,
   parameter int RST_TICKS  = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_val,
   input  logic       btn_stb,
   input  logic       tick,
   input  logic       ack,
   output logic       btn_state,
   output logic       evt_press,
   output logic       evt_rel,
   output logic       evt_short,
   output logic       evt_long,
   output logic [1:0] sticky,
   output logic       rst_req
);

   localparam int DW = (DEB_N > 1) ? $clog2(DEB_N) : 1;
   localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_N - 1);
   localparam logic [CNT_W-1:0] DUR_MAX  = '1;
   localparam logic [CNT_W-1:0] LONG_CMP = CNT_W'(LONG_TICKS);
   localparam logic [CNT_W-1:0] RST_CMP  = CNT_W'(RST_TICKS);

   typedef enum logic [1:0] {IDLE, PRESSED, LONG, ARMED} stateT;

   stateT            state;
   logic [DW-1:0]    debCnt;
   logic [CNT_W-1:0] dur;
   logic             btnPrev;
   logic             riseNow;
   logic             rise;
   logic             fall;

   assign riseNow = btn_stb && btn_val && !btn_state && (debCnt == DEB_LAST);
   assign rise    = btn_state && !btnPrev;
   assign fall    = !btn_state && btnPrev;

   // Debounce: the level flips only after DEB_N consecutive differing strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_state <= 1'b0;
         debCnt    <= '0;
      end else if (btn_stb) begin
         if (btn_val == btn_state) begin
            debCnt <= '0;
         end else if (debCnt == DEB_LAST) begin
            btn_state <= ~btn_state;
            debCnt    <= '0;
         end else begin
            debCnt <= debCnt + 1'b1;
         end
      end
   end

   // Press duration: cleared on the rising edge itself, saturating, held while released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dur <= '0;
      end else if (riseNow) begin
         dur <= '0;
      end else if (btn_state && tick && (dur != DUR_MAX)) begin
         dur <= dur + 1'b1;
      end
   end

   // Delayed level for edge detection, so events trail btn_state by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btnPrev <= 1'b0;
      end else begin
         btnPrev <= btn_state;
      end
   end

   // Press classifier; a release always wins over a threshold crossing in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         evt_press <= 1'b0;
         evt_rel   <= 1'b0;
         evt_short <= 1'b0;
         evt_long  <= 1'b0;
         rst_req   <= 1'b0;
      end else begin
         evt_press <= 1'b0;
         evt_rel   <= 1'b0;
         evt_short <= 1'b0;
         evt_long  <= 1'b0;
         rst_req   <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state     <= PRESSED;
                  evt_press <= 1'b1;
               end
            end
            PRESSED: begin
               if (fall) begin
                  state     <= IDLE;
                  evt_short <= 1'b1;
                  evt_rel   <= 1'b1;
               end else if (dur >= LONG_CMP) begin
                  state    <= LONG;
                  evt_long <= 1'b1;
               end
            end
            LONG: begin
               if (fall) begin
                  state   <= IDLE;
                  evt_rel <= 1'b1;
               end else if (dur >= RST_CMP) begin
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (fall) begin
                  state   <= IDLE;
                  evt_rel <= 1'b1;
                  rst_req <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky status: a pending set beats a simultaneous ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky <= 2'b00;
      end else begin
         sticky[0] <= evt_short | (sticky[0] & ~ack);
         sticky[1] <= evt_long  | (sticky[1] & ~ack);
      end
   end

endmodule

// File: tb/tb_btn_event.sv
// Scoreboarded bench for btn_event: stimulus queues expected event pulses with their edge,
// a monitor pops and compares whenever any event output fires.
module tb_btn_event;

   localparam int DEB_N      = 4;
   localparam int CNT_W      = 6;
   localparam int LONG_TICKS = 20;
   localparam int RST_TICKS  = 50;

   localparam logic [4:0] E_PRESS  = 5'b10000;
   localparam logic [4:0] E_REL    = 5'b01000;
   localparam logic [4:0] E_SHORT  = 5'b00100;
   localparam logic [4:0] E_LONG   = 5'b00010;
   localparam logic [4:0] E_RSTREQ = 5'b00001;

   typedef struct {
      int         atEdge;
      logic [4:0] vec;
   } expT;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_val;
   logic       btn_stb;
   logic       tick;
   logic       ack;
   logic       btn_state;
   logic       evt_press;
   logic       evt_rel;
   logic       evt_short;
   logic       evt_long;
   logic [1:0] sticky;
   logic       rst_req;

   int  edgeCnt = 0;
   int  lastEdge = 0;
   int  checks = 0;
   int  errors = 0;
   expT expQ[$];

   btn_event #(
      .DEB_N(DEB_N),
      .CNT_W(CNT_W),
      .LONG_TICKS(LONG_TICKS),
      .RST_TICKS(RST_TICKS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_val(btn_val),
      .btn_stb(btn_stb),
      .tick(tick),
      .ack(ack),
      .btn_state(btn_state),
      .evt_press(evt_press),
      .evt_rel(evt_rel),
      .evt_short(evt_short),
      .evt_long(evt_long),
      .sticky(sticky),
      .rst_req(rst_req)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: actual timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
      end
   endtask

   // One clock cycle of inputs; strobe/tick/ack are dropped again right after the edge.
   task automatic applyStimulus(input logic v, input logic s, input logic t, input logic a);
      btn_val = v;
      btn_stb = s;
      tick    = t;
      ack     = a;
      @(posedge clk);
      #1;
      lastEdge = edgeCnt;
      btn_stb  = 1'b0;
      tick     = 1'b0;
      ack      = 1'b0;
   endtask

   task automatic strobeRun(input logic v, input int n);
      for (int i = 0; i < n; i++) applyStimulus(v, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic tickRun(input int n);
      for (int i = 0; i < n; i++) applyStimulus(btn_val, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic idleRun(input int n);
      for (int i = 0; i < n; i++) applyStimulus(btn_val, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pushExp(input int atEdge, input logic [4:0] vec);
      expT e;
      e.atEdge = atEdge;
      e.vec    = vec;
      expQ.push_back(e);
   endtask

   task automatic runMonitor();
      logic [4:0] vec;
      expT        e;
      forever begin
         @(negedge clk);
         vec = {evt_press, evt_rel, evt_short, evt_long, rst_req};
         if (vec != 5'b00000) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_event: actual %b at edge %0d required none", vec, edgeCnt);
            end else begin
               e = expQ.pop_front();
               checkOutput("event_vec", int'(vec), int'(e.vec));
               checkOutput("event_edge", edgeCnt, e.atEdge);
            end
         end
      end
   endtask

   initial begin
      fork
         runMonitor();
      join_none

      rst = 1'b1; btn_val = 1'b0; btn_stb = 1'b0; tick = 1'b0; ack = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("reset_btn_state", int'(btn_state), 0);
      checkOutput("reset_sticky", int'(sticky), 0);
      checkOutput("reset_events", int'({evt_press, evt_rel, evt_short, evt_long, rst_req}), 0);

      $display("[TB] debounce with glitch 1,0,1,1,1,1");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      strobeRun(1'b1, 3);
      checkOutput("deb_not_yet", int'(btn_state), 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("deb_rise", int'(btn_state), 1);
      pushExp(lastEdge + 1, E_PRESS);

      $display("[TB] short press, 10 ticks");
      tickRun(10);
      strobeRun(1'b0, 3);
      checkOutput("deb_hold_high", int'(btn_state), 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      pushExp(lastEdge + 1, E_REL | E_SHORT);
      idleRun(3);
      checkOutput("sticky_short", int'(sticky), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("ack_clear_short", int'(sticky), 0);

      $display("[TB] long press, 25 ticks");
      strobeRun(1'b1, 4);
      pushExp(lastEdge + 1, E_PRESS);
      tickRun(20);
      pushExp(lastEdge + 1, E_LONG);
      tickRun(5);
      strobeRun(1'b0, 4);
      pushExp(lastEdge + 1, E_REL);
      idleRun(3);
      checkOutput("sticky_long", int'(sticky), 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("ack_clear_long", int'(sticky), 0);

      $display("[TB] ack colliding with evt_short");
      strobeRun(1'b1, 4);
      pushExp(lastEdge + 1, E_PRESS);
      tickRun(3);
      strobeRun(1'b0, 4);
      pushExp(lastEdge + 1, E_REL | E_SHORT);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("ack_collide", int'(sticky), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("ack_alone", int'(sticky), 0);

      $display("[TB] reset-hold press, 70 ticks with saturation");
      strobeRun(1'b1, 4);
      pushExp(lastEdge + 1, E_PRESS);
      tickRun(20);
      pushExp(lastEdge + 1, E_LONG);
      tickRun(43);
      checkOutput("dur_at_max", int'(dut.dur), 63);
      tickRun(7);
      checkOutput("dur_saturate", int'(dut.dur), 63);
      checkOutput("no_rstreq_held", int'(rst_req), 0);
      strobeRun(1'b0, 4);
      pushExp(lastEdge + 1, E_REL | E_RSTREQ);
      idleRun(3);
      checkOutput("sticky_after_rsthold", int'(sticky), 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] async reset while in LONG");
      strobeRun(1'b1, 4);
      pushExp(lastEdge + 1, E_PRESS);
      tickRun(20);
      pushExp(lastEdge + 1, E_LONG);
      tickRun(5);
      idleRun(2);
      checkOutput("sticky_before_rst", int'(sticky), 2);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_btn_state", int'(btn_state), 0);
      checkOutput("async_sticky", int'(sticky), 0);
      checkOutput("async_events", int'({evt_press, evt_rel, evt_short, evt_long, rst_req}), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      strobeRun(1'b1, 3);
      checkOutput("redetect_wait", int'(btn_state), 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("redetect_rise", int'(btn_state), 1);
      pushExp(lastEdge + 1, E_PRESS);
      strobeRun(1'b0, 4);
      pushExp(lastEdge + 1, E_REL | E_SHORT);
      idleRun(4);
      checkOutput("scoreboard_drain", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
